alarm_clock: RTL and testbench

ALARM_CLOCK -- requirements
Module: alarm_clock

---
 rtl/clock_pkg.sv | 46 ++++
 rtl/button_debounce.sv | 61 ++++++
 rtl/alarm_clock.sv | 181 ++++++++++++++++++
 tb/tb_alarm_clock.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and seven-segment helpers for the alarm clock.
package clock_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RINGING = 1'b1
  } alarm_state_e;

  // Active-low segment patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Maps the internal 0..23 hour to what the display shows.
  function automatic logic [4:0] display_hour(input logic [4:0] hour, input logic hour_12);
    if (!hour_12)      return hour;
    if (hour == 5'd0)  return 5'd12;
    if (hour > 5'd12)  return hour - 5'd12;
    return hour;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, level debouncer and rising-edge press pulse.
module button_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Synchroniser chain for the asynchronous button input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after a full run of identical differing samples
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debouncer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alarm_clock.sv
// Digital clock with button time setting, alarm and seven-segment display.
module alarm_clock
  import clock_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_DIV        = CLK_HZ,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOUR_12         = 0,
  parameter int RING_SECONDS    = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SW_0,
  input  logic       SW_1,
  input  logic       SW_2,
  input  logic       button_C,
  input  logic       button_M,
  input  logic       button_H,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic [6:0] seg4,
  output logic [6:0] seg5,
  output logic [7:0] LED
);

  localparam int  PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int  RW     = (RING_SECONDS > 1) ? $clog2(RING_SECONDS + 1) : 1;
  localparam bit  H12    = (HOUR_12 != 0);
  // Reset display: hour 0 reads "12" in 12-hour mode
  localparam logic [6:0] RST_SEG5 = H12 ? SEG_1 : SEG_0;
  localparam logic [6:0] RST_SEG4 = H12 ? SEG_2 : SEG_0;

  logic [2:0]    btn_raw, press;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d, alm_min_q, alm_min_d;
  logic [4:0]    hour_q, hour_d, alm_hour_q, alm_hour_d;
  alarm_state_e  state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [7:0]    led_q, led_d;
  logic [6:0]    seg_q [6];
  logic [6:0]    seg_d [6];

  logic       tick, ringing, any_press;
  logic       do_c, do_m, do_h;
  logic       sec_carry, min_carry;
  logic [6:0] min_sum;
  logic [5:0] hour_sum;
  logic [4:0] show_hour;
  logic [5:0] show_min;

  assign btn_raw = {button_H, button_M, button_C};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_raw[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  assign tick      = SW_0 && (presc_q == PW'(TICK_DIV - 1));
  assign ringing   = (state_q == ST_RINGING);
  assign any_press = |press;
  // A press that dismisses the alarm is swallowed
  assign do_c      = press[0] & ~ringing;
  assign do_m      = press[1] & ~ringing;
  assign do_h      = press[2] & ~ringing;

  // Prescaler, time counters and alarm setting; clear wins over everything
  always_comb begin
    presc_d    = presc_q;
    alm_min_d  = alm_min_q;
    alm_hour_d = alm_hour_q;
    if (SW_0) presc_d = tick ? '0 : presc_q + 1'b1;

    sec_carry = tick && (sec_q == 6'd59);
    min_carry = sec_carry && (min_q == 6'd59);
    sec_d     = tick ? (sec_carry ? 6'd0 : sec_q + 6'd1) : sec_q;

    min_sum  = 7'(min_q) + 7'(sec_carry) + 7'(do_m & ~SW_1);
    min_d    = (min_sum >= 7'd60) ? 6'(min_sum - 7'd60) : 6'(min_sum);
    hour_sum = 6'(hour_q) + 6'(min_carry) + 6'(do_h & ~SW_1);
    hour_d   = (hour_sum >= 6'd24) ? 5'(hour_sum - 6'd24) : 5'(hour_sum);

    if (do_m && SW_1) alm_min_d  = (alm_min_q == 6'd59) ? 6'd0 : alm_min_q + 6'd1;
    if (do_h && SW_1) alm_hour_d = (alm_hour_q == 5'd23) ? 5'd0 : alm_hour_q + 5'd1;

    if (do_c) begin
      presc_d = '0;
      sec_d   = '0;
      min_d   = '0;
      hour_d  = '0;
    end
  end

  // Alarm FSM: ring on a tick landing on hh:mm:00, stop on timeout, disarm or press
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (SW_2 && tick && !do_c && sec_d == 6'd0 &&
            min_d == alm_min_q && hour_d == alm_hour_q) begin
          state_d    = ST_RINGING;
          ring_cnt_d = '0;
        end
      end
      ST_RINGING: begin
        if (!SW_2 || any_press) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (ring_cnt_q == RW'(RING_SECONDS - 1)) state_d = ST_IDLE;
          else ring_cnt_d = ring_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status LEDs and display digits, registered from the current count
  always_comb begin
    if (ringing) led_d = sec_q[0] ? 8'h00 : 8'hFF;
    else led_d = {4'b0000, H12 && (hour_q >= 5'd12), SW_1, SW_2, SW_0};

    show_hour = display_hour(SW_1 ? alm_hour_q : hour_q, H12);
    show_min  = SW_1 ? alm_min_q : min_q;
    seg_d[5]  = seg_decode(4'(show_hour / 5'd10));
    seg_d[4]  = seg_decode(4'(show_hour % 5'd10));
    seg_d[3]  = seg_decode(4'(show_min / 6'd10));
    seg_d[2]  = seg_decode(4'(show_min % 6'd10));
    seg_d[1]  = SW_1 ? SEG_BLANK : seg_decode(4'(sec_q / 6'd10));
    seg_d[0]  = SW_1 ? SEG_BLANK : seg_decode(4'(sec_q % 6'd10));
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      alm_min_q  <= '0;
      alm_hour_q <= '0;
      state_q    <= ST_IDLE;
      ring_cnt_q <= '0;
      led_q      <= 8'h00;
      seg_q[0]   <= SEG_0;
      seg_q[1]   <= SEG_0;
      seg_q[2]   <= SEG_0;
      seg_q[3]   <= SEG_0;
      seg_q[4]   <= RST_SEG4;
      seg_q[5]   <= RST_SEG5;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      alm_min_q  <= alm_min_d;
      alm_hour_q <= alm_hour_d;
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      led_q      <= led_d;
      seg_q      <= seg_d;
    end
  end

  assign seg0 = seg_q[0];
  assign seg1 = seg_q[1];
  assign seg2 = seg_q[2];
  assign seg3 = seg_q[3];
  assign seg4 = seg_q[4];
  assign seg5 = seg_q[5];
  assign LED  = led_q;

endmodule

// File: tb/tb_alarm_clock.sv
// Scoreboard bench for alarm_clock: 24-hour and 12-hour instances share stimulus.
module tb_alarm_clock;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw0 = 1'b0, sw1 = 1'b0, sw2 = 1'b0;
  logic btn_c = 1'b0, btn_m = 1'b0, btn_h = 1'b0;

  logic [6:0] a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5;
  logic [7:0] led24, led12;
  logic [41:0] segs24, segs12;

  assign segs24 = {a5, a4, a3, a2, a1, a0};
  assign segs12 = {b5, b4, b3, b2, b1, b0};

  always #5 clk = ~clk;

  alarm_clock #(.TICK_DIV(10), .DEBOUNCE_CYCLES(4), .HOUR_12(0), .RING_SECONDS(5)) dut24 (
    .clk(clk), .rst_n(rst_n), .SW_0(sw0), .SW_1(sw1), .SW_2(sw2),
    .button_C(btn_c), .button_M(btn_m), .button_H(btn_h),
    .seg0(a0), .seg1(a1), .seg2(a2), .seg3(a3), .seg4(a4), .seg5(a5), .LED(led24));

  alarm_clock #(.TICK_DIV(10), .DEBOUNCE_CYCLES(4), .HOUR_12(1), .RING_SECONDS(5)) dut12 (
    .clk(clk), .rst_n(rst_n), .SW_0(sw0), .SW_1(sw1), .SW_2(sw2),
    .button_C(btn_c), .button_M(btn_m), .button_H(btn_h),
    .seg0(b0), .seg1(b1), .seg2(b2), .seg3(b3), .seg4(b4), .seg5(b5), .LED(led12));

  typedef struct {
    string       name;
    logic [47:0] val;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [47:0] obs;
  int          total = 0;
  int          bad = 0;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [41:0] exp_segs(input int h, input int m, input int s, input bit h12);
    int hh;
    hh = h;
    if (h12) hh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
    return {pat(hh / 10), pat(hh % 10), pat(m / 10), pat(m % 10), pat(s / 10), pat(s % 10)};
  endfunction

  task automatic push_exp(input string n, input logic [47:0] v);
    exp_t x;
    x.name = n;
    x.val  = v;
    exp_q.push_back(x);
  endtask

  task automatic press_btn(input int which);
    if (which == 0) btn_c = 1'b1; else if (which == 1) btn_m = 1'b1; else btn_h = 1'b1;
    repeat (10) @(negedge clk);
    btn_c = 1'b0; btn_m = 1'b0; btn_h = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    sw0 = 1'b1;
    repeat (n) @(negedge clk);
    sw0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    push_exp("reset_segs24", {6'b0, exp_segs(0, 0, 0, 0)});
    push_exp("reset_led24", 48'h00);
    push_exp("reset_segs12", {6'b0, exp_segs(0, 0, 0, 1)});
    push_exp("reset_led12", 48'h00);
    repeat (3) @(negedge clk);
    obs = {6'b0, segs24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    obs = {40'b0, led24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    obs = {6'b0, segs12}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    obs = {40'b0, led12}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
  endtask

  task automatic test_run;
    rst_n = 1'b1;
    sw0 = 1'b1;
    push_exp("run_led", 48'h01);
    push_exp("run_6000", {6'b0, exp_segs(0, 10, 0, 0)});
    repeat (5) @(negedge clk);
    obs = {40'b0, led24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    repeat (5995) @(negedge clk);
    sw0 = 1'b0;
    repeat (2) @(negedge clk);
    obs = {6'b0, segs24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
  endtask

  task automatic test_debounce;
    push_exp("glitch_1cyc", {6'b0, exp_segs(0, 10, 0, 0)});
    btn_m = 1'b1; @(negedge clk); btn_m = 1'b0;
    repeat (20) @(negedge clk);
    obs = {6'b0, segs24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    push_exp("glitch_3cyc", {6'b0, exp_segs(0, 10, 0, 0)});
    btn_m = 1'b1; repeat (3) @(negedge clk); btn_m = 1'b0;
    repeat (20) @(negedge clk);
    obs = {6'b0, segs24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    push_exp("held_press", {6'b0, exp_segs(0, 11, 0, 0)});
    press_btn(1);
    repeat (20) @(negedge clk);
    obs = {6'b0, segs24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
  endtask

  task automatic test_clear;
    push_exp("clear", {6'b0, exp_segs(0, 0, 0, 0)});
    press_btn(0);
    obs = {6'b0, segs24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
  endtask

  task automatic test_wrap;
    push_exp("hour13_24h", {6'b0, exp_segs(13, 0, 0, 0)});
    push_exp("hour13_12h", {6'b0, exp_segs(13, 0, 0, 1)});
    push_exp("hour13_pm", 48'h1);
    for (int i = 0; i < 13; i++) press_btn(2);
    obs = {6'b0, segs24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    obs = {6'b0, segs12}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    obs = {47'b0, led12[3]}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    for (int i = 0; i < 10; i++) press_btn(2);
    for (int i = 0; i < 59; i++) press_btn(1);
    push_exp("preset_235959", {6'b0, exp_segs(23, 59, 59, 0)});
    run_cycles(590);
    obs = {6'b0, segs24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    push_exp("day_wrap", {6'b0, exp_segs(0, 0, 0, 0)});
    push_exp("midnight_12h", {6'b0, exp_segs(0, 0, 0, 1)});
    push_exp("midnight_pm", 48'h0);
    run_cycles(10);
    obs = {6'b0, segs24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    obs = {6'b0, segs12}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    obs = {47'b0, led12[3]}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    push_exp("frozen", {6'b0, exp_segs(0, 0, 0, 0)});
    repeat (100) @(negedge clk);
    obs = {6'b0, segs24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
  endtask

  task automatic test_coincident;
    press_btn(0);
    for (int i = 0; i < 59; i++) press_btn(1);
    run_cycles(590);
    // Press pulse is timed to land on the tick that carries out of 00:59:59
    push_exp("press_on_carry", {6'b0, exp_segs(1, 1, 0, 0)});
    sw0 = 1'b1;
    repeat (3) @(negedge clk);
    btn_m = 1'b1;
    repeat (10) @(negedge clk);
    sw0 = 1'b0;
    btn_m = 1'b0;
    repeat (2) @(negedge clk);
    obs = {6'b0, segs24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
  endtask

  task automatic test_alarm_ring;
    int n;
    press_btn(0);
    sw1 = 1'b1;
    press_btn(1);
    press_btn(1);
    push_exp("alarm_view", {6'b0, 7'h40, 7'h40, 7'h40, 7'h24, 7'h7F, 7'h7F});
    obs = {6'b0, segs24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    sw1 = 1'b0;
    sw2 = 1'b1;
    sw0 = 1'b1;
    push_exp("ring_start", 48'hFF);
    push_exp("ring_time", {6'b0, exp_segs(0, 2, 0, 0)});
    push_exp("ring_odd", 48'h00);
    push_exp("ring_even", 48'hFF);
    push_exp("ring_last", 48'hFF);
    push_exp("ring_timeout", 48'h03);
    n = 0;
    while (led24 !== 8'hFF && n < 1500) begin @(negedge clk); n++; end
    obs = {40'b0, led24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    obs = {6'b0, segs24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    repeat (10) @(negedge clk);
    obs = {40'b0, led24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    repeat (10) @(negedge clk);
    obs = {40'b0, led24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    repeat (25) @(negedge clk);
    obs = {40'b0, led24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    repeat (10) @(negedge clk);
    obs = {40'b0, led24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
  endtask

  task automatic test_dismiss;
    int n;
    sw1 = 1'b1;
    press_btn(1);
    sw1 = 1'b0;
    push_exp("ring_0300", 48'hFF);
    push_exp("dismiss_led", 48'h03);
    push_exp("dismiss_keeps_time", {34'b0, 7'h40, 7'h30});
    n = 0;
    while (led24 !== 8'hFF && n < 1500) begin @(negedge clk); n++; end
    obs = {40'b0, led24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    press_btn(0);
    obs = {40'b0, led24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    sw0 = 1'b0;
    repeat (2) @(negedge clk);
    obs = {34'b0, a3, a2}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
  endtask

  task automatic test_reset_midring;
    int n;
    sw1 = 1'b1;
    press_btn(1);
    sw1 = 1'b0;
    sw0 = 1'b1;
    push_exp("ring_0400", 48'hFF);
    push_exp("midring_rst_led", 48'h00);
    push_exp("midring_rst_segs", {6'b0, exp_segs(0, 0, 0, 0)});
    push_exp("after_rst_idle", 48'h02);
    n = 0;
    while (led24 !== 8'hFF && n < 1500) begin @(negedge clk); n++; end
    obs = {40'b0, led24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    rst_n = 1'b0;
    #1;
    obs = {40'b0, led24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    obs = {6'b0, segs24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
    sw0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    obs = {40'b0, led24}; e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
    else $display("ok   %s: %h", e.name, obs);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_run;
    test_debounce;
    test_clear;
    test_wrap;
    test_coincident;
    test_alarm_ring;
    test_dismiss;
    test_reset_midring;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
